braille_tx: RTL

BRAILLE_TX -- requirements
Module: braille_tx

---
 rtl/braille_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/braille_tx.sv
// Grade-1 Braille cell transmitter: accepts ASCII characters and presents
// timed 6-dot cells, inserting the number sign before a run of digits.
module braille_tx #(
  parameter int unsigned HOLD_CYCLES = 32'd25000000,
  parameter int unsigned GAP_CYCLES  = 32'd5000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] cell_out,
  output logic       cell_valid,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned DOT_W = 6;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned IDX_W = 5;

  localparam logic [DOT_W-1:0] NUM_SIGN  = 6'b010111;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    CELL   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             num_mode, num_mode_d;
  logic [DOT_W-1:0] cell_q, cell_q_d;

  logic [OUT_W-1:0] cell_out_d;
  logic             cell_valid_d, busy_d, err_d, in_ready_d;

  logic             is_upper, is_lower, is_digit, is_space;
  logic [IDX_W-1:0] letter_idx;
  logic [DOT_W-1:0] in_cell;
  logic             accept;

  // Dots ordered {1,4,2,5,3,6} from MSB to LSB; index 0 = 'a'.
  function automatic logic [DOT_W-1:0] letter_cell(input logic [IDX_W-1:0] idx);
    logic [DOT_W-1:0] c;
    case (idx)
      5'd0:  c = 6'b100000;
      5'd1:  c = 6'b101000;
      5'd2:  c = 6'b110000;
      5'd3:  c = 6'b110100;
      5'd4:  c = 6'b100100;
      5'd5:  c = 6'b111000;
      5'd6:  c = 6'b111100;
      5'd7:  c = 6'b101100;
      5'd8:  c = 6'b011000;
      5'd9:  c = 6'b011100;
      5'd10: c = 6'b100010;
      5'd11: c = 6'b101010;
      5'd12: c = 6'b110010;
      5'd13: c = 6'b110110;
      5'd14: c = 6'b100110;
      5'd15: c = 6'b111010;
      5'd16: c = 6'b111110;
      5'd17: c = 6'b101110;
      5'd18: c = 6'b011010;
      5'd19: c = 6'b011110;
      5'd20: c = 6'b100011;
      5'd21: c = 6'b101011;
      5'd22: c = 6'b011101;
      5'd23: c = 6'b110011;
      5'd24: c = 6'b110111;
      5'd25: c = 6'b100111;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Character classification; letters share low 5 bits across cases, digits reuse a..j.
  always_comb begin
    is_upper   = (in_data >= 8'h41) && (in_data <= 8'h5A);
    is_lower   = (in_data >= 8'h61) && (in_data <= 8'h7A);
    is_digit   = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_space   = (in_data == 8'h20);
    letter_idx = '0;
    if (is_upper || is_lower) begin
      letter_idx = in_data[4:0] - 5'd1;
    end else if (is_digit) begin
      letter_idx = (in_data[3:0] == 4'd0) ? 5'd9 : ({1'b0, in_data[3:0]} - 5'd1);
    end
    in_cell = is_space ? '0 : letter_cell(letter_idx);
  end

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cnt      <= '0;
      num_mode <= 1'b0;
      cell_q   <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      num_mode <= num_mode_d;
      cell_q   <= cell_q_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    num_mode_d = num_mode;
    cell_q_d   = cell_q;
    err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_digit) begin
            cell_q_d = in_cell;
            cnt_d    = HOLD_LOAD;
            if (!num_mode) begin
              state_d    = PREFIX;
              num_mode_d = 1'b1;
            end else begin
              state_d = CELL;
            end
          end else if (is_upper || is_lower || is_space) begin
            cell_q_d   = in_cell;
            cnt_d      = HOLD_LOAD;
            num_mode_d = 1'b0;
            state_d    = CELL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PREFIX: begin
        if (cnt == '0) begin
          state_d = CELL;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      CELL: begin
        if (cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs track the state register.
  always_comb begin
    cell_out_d   = {num_mode_d, 3'b000, 6'b000000};
    cell_valid_d = 1'b0;
    busy_d       = (state_d != IDLE);
    in_ready_d   = (state_d == IDLE);
    case (state_d)
      PREFIX: begin
        cell_out_d[DOT_W-1:0] = NUM_SIGN;
        cell_valid_d          = 1'b1;
      end
      CELL: begin
        cell_out_d[DOT_W-1:0] = cell_q_d;
        cell_valid_d          = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      cell_out   <= '0;
      cell_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      cell_out   <= cell_out_d;
      cell_valid <= cell_valid_d;
      busy       <= busy_d;
      err        <= err_d;
      in_ready   <= in_ready_d;
    end
  end

endmodule
